// File: rtl/sos_cascade_ctrl.sv
// sos_cascade_ctrl: control plane for a cascade of NSEC scaled second-order
// sections. It holds a shadow and an active coefficient bank, swaps them on
// commit (optionally clearing section state), gates the section clock enable
// with a ready/valid handshake, suppresses output until the pipeline is primed,
// and keeps a sticky overflow flag.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   cfg_wr/addr/data  shadow-bank write; cfg_addr = {section, index},
//                     index 0..6 = b0,b1,b2,a0,a1,a2,scale
//   cfg_commit        request a shadow->active copy
//   cfg_busy          commit in progress (PEND or CLR)
//   cfg_err           one-cycle pulse after a rejected write
//   in_valid/in_ready, out_valid/out_ready   sample handshakes
//   sec_ce, sec_clr   section clock enable / one-cycle section clear
//   coef_out          active bank, section 0 index 0 in the LSBs
//   ovf_in, ovf_clr, ovf_sticky   overflow flags in, clear, sticky flag out
module sos_cascade_ctrl #(
  parameter int NSEC        = 4,
  parameter int WIS         = 5,
  parameter int WFS         = 11,
  parameter int PLAT        = 2,
  parameter int CLR_ON_SWAP = 1,
  localparam int WC         = WIS + WFS,
  localparam int AW         = $clog2(NSEC) + 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cfg_wr,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [WC-1:0]        cfg_data,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sec_ce,
  output logic                 sec_clr,
  output logic [NSEC*7*WC-1:0] coef_out,
  input  logic [NSEC*4-1:0]    ovf_in,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky
);

  localparam int FW = $clog2(PLAT + 1);
  localparam logic [FW-1:0] PLAT_F = FW'(PLAT);
  localparam logic [WC-1:0] ONE    = WC'(1) << WFS;

  typedef enum logic [1:0] {RUN, PEND, CLR} state_t;

  state_t          state;
  logic [FW-1:0]   fill;
  logic [WC-1:0]   shadow [NSEC][7];
  logic [WC-1:0]   active [NSEC][7];

  logic [2:0]      wr_idx;
  int              wr_sec;
  logic            wr_ok;
  logic            primed;

  // Pass-through section: b0 = a0 = scale = 1.0, all others zero.
  function automatic logic [WC-1:0] pass_val(input int k);
    return (k == 0 || k == 3 || k == 6) ? ONE : '0;
  endfunction

  always_comb begin
    wr_idx    = cfg_addr[2:0];
    wr_sec    = int'(cfg_addr[AW-1:3]);
    wr_ok     = cfg_wr && (wr_idx != 3'd7) && (wr_sec < NSEC) && !cfg_busy;
    primed    = (fill == PLAT_F);
    in_ready  = (state == RUN) && (!primed || out_ready);
    sec_ce    = in_valid && in_ready;
    // Output is valid only once the pipeline holds PLAT real samples.
    out_valid = sec_ce && primed;
  end

  for (genvar s = 0; s < NSEC; s++) begin : g_sec
    for (genvar k = 0; k < 7; k++) begin : g_coef
      assign coef_out[(s*7+k)*WC +: WC] = active[s][k];
    end
  end

  // Swap FSM, fill counter and active bank.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      cfg_busy <= 1'b0;
      sec_clr  <= 1'b1;
      fill     <= '0;
      for (int s = 0; s < NSEC; s++)
        for (int k = 0; k < 7; k++)
          active[s][k] <= pass_val(k);
    end else begin
      sec_clr <= 1'b0;
      if (sec_ce && !primed) fill <= fill + 1'b1;
      unique case (state)
        RUN: begin
          if (cfg_commit) begin
            state    <= PEND;
            cfg_busy <= 1'b1;
          end
        end
        PEND: begin
          // A write issued alongside the commit has already landed in shadow.
          for (int s = 0; s < NSEC; s++)
            for (int k = 0; k < 7; k++)
              active[s][k] <= shadow[s][k];
          if (CLR_ON_SWAP != 0) begin
            state   <= CLR;
            sec_clr <= 1'b1;
          end else begin
            state    <= RUN;
            cfg_busy <= 1'b0;
          end
        end
        CLR: begin
          fill     <= '0;
          state    <= RUN;
          cfg_busy <= 1'b0;
        end
        default: begin
          state    <= RUN;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

  // Shadow bank and write error pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_err <= 1'b0;
      for (int s = 0; s < NSEC; s++)
        for (int k = 0; k < 7; k++)
          shadow[s][k] <= pass_val(k);
    end else begin
      cfg_err <= cfg_wr && !wr_ok;
      for (int s = 0; s < NSEC; s++)
        for (int k = 0; k < 7; k++)
          if (wr_ok && wr_sec == s && wr_idx == 3'(k))
            shadow[s][k] <= cfg_data;
    end
  end

  // Sticky overflow; a new overflow beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST)                    ovf_sticky <= 1'b0;
    else if (sec_ce && |ovf_in) ovf_sticky <= 1'b1;
    else if (ovf_clr)           ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_sos_cascade_ctrl.sv
// Testbench for sos_cascade_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_sos_cascade_ctrl;
  localparam int NSEC = 4, WIS = 5, WFS = 11, PLAT = 2, CLR_ON_SWAP = 1;
  localparam int WC = WIS + WFS, AW = $clog2(NSEC) + 3, CW = NSEC*7*WC;

  logic          CLK, RST;
  logic          cfg_wr, cfg_commit, cfg_busy, cfg_err;
  logic [AW-1:0] cfg_addr;
  logic [WC-1:0] cfg_data;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic          sec_ce, sec_clr, ovf_clr, ovf_sticky;
  logic [CW-1:0] coef_out;
  logic [NSEC*4-1:0] ovf_in;

  sos_cascade_ctrl #(.NSEC(NSEC), .WIS(WIS), .WFS(WFS), .PLAT(PLAT),
                     .CLR_ON_SWAP(CLR_ON_SWAP)) dut (
    .CLK(CLK), .RST(RST), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .sec_ce(sec_ce),
    .sec_clr(sec_clr), .coef_out(coef_out), .ovf_in(ovf_in),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [CW-1:0] got,
                       input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: banks as arrays, swap as a busy countdown (2 = copy
  // pending, 1 = clearing), priming as "samples accepted since last clear".
  logic [WC-1:0] sh [NSEC][7];
  logic [WC-1:0] ac [NSEC][7];
  int  busy_cnt, accepted;
  bit  m_clr, m_err, m_sticky;

  function automatic logic [WC-1:0] passv(input int k);
    return (k == 0 || k == 3 || k == 6) ? WC'(1 << WFS) : '0;
  endfunction

  function automatic logic [CW-1:0] pack_ac();
    logic [CW-1:0] v;
    v = '0;
    for (int s = 0; s < NSEC; s++)
      for (int k = 0; k < 7; k++)
        v[(s*7+k)*WC +: WC] = ac[s][k];
    return v;
  endfunction

  task automatic tick(input bit chk);
    bit run, rdy, ce;
    int sec, idx;
    run = (busy_cnt == 0);
    rdy = run && (accepted < PLAT || out_ready);
    ce  = in_valid && rdy;
    if (chk) begin
      @(negedge CLK);
      check("in_ready",   CW'(in_ready),   CW'(rdy));
      check("sec_ce",     CW'(sec_ce),     CW'(ce));
      check("out_valid",  CW'(out_valid),  CW'(ce && accepted >= PLAT));
      check("cfg_busy",   CW'(cfg_busy),   CW'(!run));
      check("sec_clr",    CW'(sec_clr),    CW'(m_clr));
      check("cfg_err",    CW'(cfg_err),    CW'(m_err));
      check("ovf_sticky", CW'(ovf_sticky), CW'(m_sticky));
      check("coef_out",   coef_out,        pack_ac());
    end
    @(posedge CLK);
    if (RST) begin
      for (int s = 0; s < NSEC; s++)
        for (int k = 0; k < 7; k++) begin
          sh[s][k] = passv(k);
          ac[s][k] = passv(k);
        end
      busy_cnt = 0; accepted = 0;
      m_clr = 1; m_err = 0; m_sticky = 0;
    end else begin
      sec = int'(cfg_addr) >> 3;
      idx = int'(cfg_addr) & 7;
      m_err = cfg_wr && !(idx < 7 && sec < NSEC && run);
      m_clr = (busy_cnt == 2) && (CLR_ON_SWAP != 0);
      if (busy_cnt == 2)
        for (int s = 0; s < NSEC; s++)
          for (int k = 0; k < 7; k++) ac[s][k] = sh[s][k];
      if (cfg_wr && !m_err) sh[sec][idx] = cfg_data;
      if (ce && ovf_in != 0) m_sticky = 1;
      else if (ovf_clr)      m_sticky = 0;
      if (busy_cnt == 1)               accepted = 0;
      else if (ce && accepted < PLAT)  accepted++;
      if (busy_cnt == 2)      busy_cnt = (CLR_ON_SWAP != 0) ? 1 : 0;
      else if (busy_cnt == 1) busy_cnt = 0;
      else if (cfg_commit)    busy_cnt = 2;
    end
    #1;
  endtask

  task automatic idle();
    cfg_wr = 0; cfg_commit = 0; in_valid = 0; out_ready = 0;
    ovf_in = '0; ovf_clr = 0; RST = 0; cfg_addr = '0; cfg_data = '0;
  endtask

  initial begin
    idle();
    RST = 1;
    tick(0);
    tick(1);
    RST = 0;

    // Stream 5 samples: first PLAT are priming samples.
    in_valid = 1; out_ready = 1;
    repeat (5) tick(1);
    in_valid = 0;
    tick(1);

    // Write section 1 b2, then commit.
    cfg_wr = 1; cfg_addr = AW'((1 << 3) | 2); cfg_data = 16'h1234;
    tick(1);
    cfg_wr = 0; cfg_commit = 1;
    tick(1);
    cfg_commit = 0; in_valid = 1;
    repeat (4) tick(1);
    in_valid = 0;

    // Rejected write (index 7) and write during busy.
    cfg_wr = 1; cfg_addr = AW'((2 << 3) | 7); cfg_data = 16'hdead;
    tick(1);
    cfg_commit = 1; cfg_addr = AW'(3 << 3); cfg_data = 16'h0badd;
    tick(1);
    cfg_commit = 0; cfg_addr = AW'(0);
    tick(1);
    cfg_wr = 0;
    repeat (3) tick(1);

    // Back-pressure once primed.
    in_valid = 1; out_ready = 0;
    repeat (4) tick(1);
    out_ready = 1;
    tick(1);
    in_valid = 0;

    // Overflow set beats clear; later clear alone.
    in_valid = 1; ovf_in = 16'h0020; ovf_clr = 1;
    tick(1);
    in_valid = 0; ovf_in = '0; ovf_clr = 0;
    tick(1);
    ovf_clr = 1;
    tick(1);
    ovf_clr = 0;

    // Write+commit together, then reset during PEND.
    cfg_wr = 1; cfg_commit = 1; cfg_addr = AW'((2 << 3) | 4); cfg_data = 16'h7777;
    tick(1);
    cfg_wr = 0; cfg_commit = 0;
    repeat (3) tick(1);
    cfg_commit = 1;
    tick(1);
    cfg_commit = 0; RST = 1;
    tick(1);
    RST = 0;
    repeat (3) tick(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cfg_wr     = ($urandom_range(0, 9) < 2);
      cfg_addr   = AW'($urandom_range(0, (1 << AW) - 1));
      cfg_data   = WC'($urandom);
      cfg_commit = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 9) < 6);
      out_ready  = ($urandom_range(0, 9) < 6);
      ovf_in     = ($urandom_range(0, 15) == 0) ? (NSEC*4)'(1 << $urandom_range(0, NSEC*4-1)) : '0;
      ovf_clr    = ($urandom_range(0, 9) == 0);
      RST        = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    idle();
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
